clock_mode_controller: RTL and testbench

Sequencing and adjust controller for the digital-clock timekeeping datapath. Drives the enable and direction inputs of three wrap-around up/down counters: seconds (mod 60), minutes (mod 60) and hours (mod 24). It cascades them from a 1 Hz tick in run mode and steers debounced user buttons to the selected field in set mode. It sits between the button/tick front end and the counter bank, and feeds the display its blink and mode indications.

---
 rtl/clock_mode_controller_pkg.sv | 29 ++
 rtl/clock_mode_controller_adjust_timeout.sv | 38 +++
 rtl/clock_mode_controller.sv | 151 +++++++++++++++
 tb/tb_clock_mode_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_mode_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_mode_controller_pkg
// Brief   : Shared definitions for the digital-clock mode controller:
//           mode state encoding, field maxima and default counter widths.
// Revision: 1.0 - initial release
// ============================================================================
package clock_mode_controller_pkg;

  // Controller modes: free-running timekeeping, or adjusting one field
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_state_t;

  // Largest value each counter holds before wrapping
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // Default counter widths and idle-tick limit in set mode
  localparam int DEF_SEC_W   = 6;
  localparam int DEF_MIN_W   = 6;
  localparam int DEF_HR_W    = 5;
  localparam int DEF_TIMEOUT = 30;

endpackage
`default_nettype wire

// File: rtl/clock_mode_controller_adjust_timeout.sv
`default_nettype none
// ============================================================================
// Module  : adjust_timeout
// Brief   : Idle-tick counter for the set states. Counts ticks, clears on
//           request, and flags the tick that completes TIMEOUT idle ticks.
// Revision: 1.0 - initial release
// ============================================================================
module adjust_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Idle counter: clear has priority over tick; saturates at TIMEOUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != CNT_W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is flagged in the same cycle as the tick that completes the run,
  // so the owner can leave the set state on that very edge.
  assign expired = tick && (count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/clock_mode_controller.sv
`default_nettype none
// ============================================================================
// Module  : clock_mode_controller
// Brief   : Run/set sequencing for the sec/min/hr counter bank. Cascades the
//           1 Hz tick in run mode and steers up/down buttons to the selected
//           field in set mode, with idle timeout and display blink.
// Revision: 1.0 - initial release
// ============================================================================
module clock_mode_controller
  import clock_mode_controller_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SEC_W   = DEF_SEC_W,
  parameter int MIN_W   = DEF_MIN_W,
  parameter int HR_W    = DEF_HR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic [SEC_W-1:0] sec,
  input  logic [MIN_W-1:0] min,
  input  logic [HR_W-1:0]  hr,
  output logic             sec_en,
  output logic             min_en,
  output logic             hr_en,
  output logic             sec_ud,
  output logic             min_ud,
  output logic             hr_ud,
  output logic             set_mode,
  output logic             sel_hr,
  output logic             sel_min,
  output logic             blink
);

  mode_state_t state, state_nxt;
  logic        any_btn;
  logic        adjust;
  logic        state_change;
  logic        timeout_clear;
  logic        expired;
  logic        sec_at_max;
  logic        min_at_max;

  // Hours never gate the cascade; the counter wraps itself at 23
  logic        unused_hr;
  assign unused_hr = ^hr;

  assign any_btn      = btn_mode | btn_up | btn_down;
  // A single direction press with no mode press moves the selected field
  assign adjust       = (btn_up ^ btn_down) & ~btn_mode;
  assign sec_at_max   = (sec == SEC_W'(SEC_MAX));
  assign min_at_max   = (min == MIN_W'(MIN_MAX));
  assign state_change = (state_nxt != state);
  // Idle count is only meaningful inside a set state
  assign timeout_clear = any_btn | state_change | (state == RUN);

  adjust_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_adjust_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timeout_clear),
    .tick    (tick),
    .expired (expired)
  );

  // Mode state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next mode: mode button cycles, timeout returns to RUN unless a button is seen
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (btn_mode) state_nxt = SET_HR;
      end
      SET_HR: begin
        if (btn_mode)                 state_nxt = SET_MIN;
        else if (!any_btn && expired) state_nxt = RUN;
      end
      SET_MIN: begin
        if (btn_mode)                 state_nxt = RUN;
        else if (!any_btn && expired) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Blink phase: restarts low on any mode change, toggles on tick while adjusting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink <= 1'b0;
    end else if (state_change || (state == RUN)) begin
      blink <= 1'b0;
    end else if (tick) begin
      blink <= ~blink;
    end
  end

  // Counter enables/directions and mode indications from state and pulses
  always_comb begin
    sec_en   = 1'b0;
    min_en   = 1'b0;
    hr_en    = 1'b0;
    sec_ud   = 1'b1;
    min_ud   = 1'b1;
    hr_ud    = 1'b1;
    set_mode = 1'b0;
    sel_hr   = 1'b0;
    sel_min  = 1'b0;
    case (state)
      RUN: begin
        sec_en = tick;
        min_en = tick & sec_at_max;
        hr_en  = tick & sec_at_max & min_at_max;
      end
      SET_HR: begin
        set_mode = 1'b1;
        sel_hr   = 1'b1;
        hr_en    = adjust;
        hr_ud    = btn_up;
      end
      SET_MIN: begin
        set_mode = 1'b1;
        sel_min  = 1'b1;
        min_en   = adjust;
        min_ud   = btn_up;
      end
      default: begin
        set_mode = 1'b0;
      end
    endcase
    // Counters must not move while reset is held
    if (!reset_n) begin
      sec_en = 1'b0;
      min_en = 1'b0;
      hr_en  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_clock_mode_controller
// Brief   : Self-checking bench for clock_mode_controller. A behavioural
//           model (mode number, idle count, blink, counter values as plain
//           integers) predicts every output each cycle; directed scenarios
//           add hand-computed expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clock_mode_controller;

  localparam int TO = 30;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic sec_en, min_en, hr_en, sec_ud, min_ud, hr_ud;
  logic set_mode, sel_hr, sel_min, blink;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0=run, 1=set hours, 2=set minutes
  int m_mode = 0, m_idle = 0;
  bit m_blink = 1'b0;
  int m_sec = 0, m_min = 0, m_hr = 0;
  // Preset request for the external counters
  bit ld = 1'b0;
  int ld_s = 0, ld_m = 0, ld_h = 0;

  assign sec = 6'(m_sec);
  assign min = 6'(m_min);
  assign hr  = 5'(m_hr);

  clock_mode_controller #(
    .TIMEOUT (TO),
    .SEC_W   (6),
    .MIN_W   (6),
    .HR_W    (5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .sec_ud   (sec_ud),
    .min_ud   (min_ud),
    .hr_ud    (hr_ud),
    .set_mode (set_mode),
    .sel_hr   (sel_hr),
    .sel_min  (sel_min),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs {sec_en,min_en,hr_en,sec_ud,min_ud,hr_ud,set_mode,sel_hr,sel_min,blink}
  function automatic logic [9:0] exp_vec();
    logic se, me, he, su, mu, hu;
    bit adj;
    se = 0; me = 0; he = 0; su = 1; mu = 1; hu = 1;
    adj = (btn_up != btn_down) && !btn_mode;
    if (m_mode == 0) begin
      se = tick;
      me = tick && (m_sec == 59);
      he = tick && (m_sec == 59) && (m_min == 59);
    end else if (m_mode == 1) begin
      he = adj; hu = btn_up;
    end else begin
      me = adj; mu = btn_up;
    end
    if (!reset_n) begin se = 0; me = 0; he = 0; end
    return {se, me, he, su, mu, hu, logic'(m_mode != 0), logic'(m_mode == 1),
            logic'(m_mode == 2), logic'(m_blink)};
  endfunction

  // Model update on each edge; counters follow the model's own enables
  always @(posedge clk or negedge reset_n) begin
    logic [9:0] e;
    if (!reset_n) begin
      m_mode = 0; m_idle = 0; m_blink = 0;
    end else begin
      e = exp_vec();
      if (ld) begin
        m_sec = ld_s; m_min = ld_m; m_hr = ld_h;
      end else begin
        if (e[9]) m_sec = (m_sec + 1) % 60;
        if (e[8]) m_min = e[5] ? (m_min + 1) % 60 : (m_min + 59) % 60;
        if (e[7]) m_hr  = e[4] ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
      end
      if (btn_mode) begin
        m_mode = (m_mode + 1) % 3; m_idle = 0; m_blink = 0;
      end else if (m_mode != 0) begin
        if (btn_up || btn_down) begin
          m_idle = 0;
          if (tick) m_blink = ~m_blink;
        end else if (tick) begin
          m_idle++;
          if (m_idle >= TO) begin
            m_mode = 0; m_idle = 0; m_blink = 0;
          end else begin
            m_blink = ~m_blink;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("cycle_outputs",
        {22'd0, sec_en, min_en, hr_en, sec_ud, min_ud, hr_ud, set_mode, sel_hr, sel_min, blink},
        {22'd0, exp_vec()});
  end

  task automatic set_in(input logic t, input logic m, input logic u, input logic d);
    tick = t; btn_mode = m; btn_up = u; btn_down = d;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0);
  endtask

  task automatic cyc(input logic t, input logic m, input logic u, input logic d);
    set_in(t, m, u, d);
    adv();
  endtask

  task automatic load(input int s, input int m, input int h);
    ld = 1; ld_s = s; ld_m = m; ld_h = h;
    @(posedge clk);
    #1;
    ld = 0;
  endtask

  initial begin
    int h0;
    // Reset state, with a tick offered that must not enable anything
    #1;
    set_in(1, 0, 0, 0);
    #1;
    chk("reset_sec_en", sec_en, 0);
    chk("reset_set_mode", set_mode, 0);
    chk("reset_ud", {sec_ud, min_ud, hr_ud}, 3'b111);
    set_in(0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1;

    // Full rollover 23:59:59 -> 00:00:00
    load(59, 59, 23);
    set_in(1, 0, 0, 0);
    #2;
    chk("rollover_en", {sec_en, min_en, hr_en}, 3'b111);
    adv();
    chk("rollover_time", {sec, min, 1'b0, hr}, {6'd0, 6'd0, 1'b0, 5'd0});

    // Partial cascade
    load(59, 10, 5);
    set_in(1, 0, 0, 0);
    #2;
    chk("partial_en", {sec_en, min_en, hr_en}, 3'b110);
    adv();
    chk("partial_time", {sec, min, 1'b0, hr}, {6'd0, 6'd11, 1'b0, 5'd5});

    // Hours adjust: down from 0 wraps to 23
    load(30, 10, 0);
    cyc(0, 1, 0, 0);
    chk("sethr_sel", {set_mode, sel_hr, sel_min}, 3'b110);
    set_in(0, 0, 0, 1);
    #2;
    chk("hr_down_en", {hr_en, hr_ud, min_en, sec_en}, 4'b1000);
    adv();
    chk("hr_wrap", hr, 5'd23);
    set_in(1, 0, 0, 0);
    #2;
    chk("set_sec_frozen", sec_en, 0);
    adv();
    chk("blink_on", blink, 1);
    cyc(1, 0, 0, 0);
    chk("blink_off", blink, 0);

    // SET_MIN: mode + up together -> mode wins
    cyc(0, 1, 0, 0);
    chk("setmin_sel", {set_mode, sel_hr, sel_min}, 3'b101);
    set_in(0, 1, 1, 0);
    #2;
    chk("mode_wins_en", min_en, 0);
    adv();
    chk("mode_wins_run", set_mode, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    set_in(0, 0, 1, 1);
    #2;
    chk("up_down_ignored", {sec_en, min_en, hr_en}, 3'b000);
    adv();
    set_in(0, 0, 1, 0);
    #2;
    chk("min_up", {min_en, min_ud}, 2'b11);
    adv();
    cyc(0, 1, 0, 0);

    // Timeout after exactly TO idle ticks
    cyc(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("before_timeout", set_mode, 1);
    cyc(1, 0, 0, 0);
    chk("timeout_run", set_mode, 0);

    // Button on the TO-th tick keeps SET_HR and moves hours
    cyc(0, 1, 0, 0);
    h0 = m_hr;
    for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0);
    set_in(1, 0, 1, 0);
    #2;
    chk("timeout_btn_en", {hr_en, hr_ud}, 2'b11);
    adv();
    chk("timeout_btn_stay", {set_mode, sel_hr}, 2'b11);
    chk("timeout_btn_hr", {27'd0, hr}, 32'((h0 + 1) % 24));
    cyc(1, 0, 0, 0);
    chk("idle_restarted", set_mode, 1);

    // Asynchronous reset mid-adjust in SET_MIN with blink high
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("pre_reset_blink", {sel_min, blink}, 2'b11);
    #2;
    btn_up = 1;
    reset_n = 0;
    #1;
    chk("async_reset", {set_mode, blink, sec_en, min_en, hr_en}, 5'b00000);
    btn_up = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    cyc(0, 0, 0, 0);
    chk("after_reset_run", {set_mode, sel_hr, sel_min}, 3'b000);
    set_in(1, 0, 0, 0);
    #2;
    chk("after_reset_tick", sec_en, 1);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
